// File: rtl/instruction_prefetch_unit_if.sv
// Bus and decode-side signal bundle for the instruction prefetch unit.
// master = prefetch unit side, slave = memory controller / decode / testbench side.
interface instruction_prefetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            size;
    logic [1:0]            prot;
    logic [1:0]            trans;
    logic                  write;
    logic [31:0]           rdata;
    logic                  abort;
    logic                  flush;
    logic [ADDR_WIDTH-1:0] flush_addr;
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] instr_addr;
    logic                  instr_valid;
    logic                  instr_abort;
    logic                  instr_ready;

    modport master (
        output addr, size, prot, trans, write,
        input  rdata, abort, flush, flush_addr,
        output instr, instr_addr, instr_valid, instr_abort,
        input  instr_ready
    );

    modport slave (
        input  addr, size, prot, trans, write,
        output rdata, abort, flush, flush_addr,
        input  instr, instr_addr, instr_valid, instr_abort,
        output instr_ready
    );
endinterface

// File: rtl/instruction_prefetch_unit.sv
// Sequential opcode fetcher feeding a DEPTH-entry instruction FIFO; flush redirects the stream.
// Optional PREFETCH_ABORT_EN: aborted fetches are queued flagged and the unit halts until flush.
module instruction_prefetch_unit #(
    parameter int                    DEPTH        = 4,
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input logic                        clk,
    input logic                        reset,
    instruction_prefetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 2;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

`ifdef PREFETCH_ABORT_EN
    typedef enum logic [1:0] {S_FETCH, S_STALL, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_FETCH, S_STALL} state_t;
`endif

    state_t                state_q;
    logic [1:0]            trans_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  resp_vld_q;
    logic [ADDR_WIDTH-1:0] resp_addr_q;
    logic [PW-1:0]         wptr_q, rptr_q;
    logic [PW:0]           count_q;

    logic [31:0]           data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];

    logic                  fetching, instr_valid, enq, deq, abort_enq, slot_ok, seq_ok;
    logic [CW-1:0]         occ_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  resp_vld_d;
    logic                  unused_ok;

    assign fetching    = (trans_q != T_IDLE);
    assign instr_valid = (count_q != '0);
    assign enq         = resp_vld_q && !bus.flush;
    assign deq         = instr_valid && bus.instr_ready && !bus.flush;

    // Entries the FIFO will hold once everything already issued has landed.
    assign occ_d   = CW'(count_q) + CW'(resp_vld_q) + CW'(fetching) - CW'(deq);
    assign slot_ok = (occ_d < CW'(DEPTH));
    assign seq_ok  = fetching && (addr_q != ADDR_TOP);
    assign addr_d  = addr_q + {{(ADDR_WIDTH-3){1'b0}}, fetching, 2'b00};

`ifdef PREFETCH_ABORT_EN
    logic abt_mem [DEPTH];
    assign abort_enq       = enq && bus.abort;
    assign bus.instr_abort = instr_valid && abt_mem[rptr_q];
    assign unused_ok       = &{1'b0, bus.flush_addr[1:0]};
    always_ff @(posedge clk) begin
        if (enq && !reset) abt_mem[wptr_q] <= bus.abort;
    end
`else
    assign abort_enq       = 1'b0;
    assign bus.instr_abort = 1'b0;
    assign unused_ok       = &{1'b0, bus.abort, bus.flush_addr[1:0], state_q};
`endif

    // A fetch shown in a flush or abort cycle returns next cycle and is dropped.
    assign resp_vld_d = fetching && !bus.flush && !abort_enq;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            trans_q <= T_IDLE;
            addr_q  <= RESET_VECTOR;
        end else if (bus.flush) begin
            state_q <= S_FETCH;
            trans_q <= T_NONSEQ;
            addr_q  <= {bus.flush_addr[ADDR_WIDTH-1:2], 2'b00};
        end else begin
            addr_q  <= addr_d;
            trans_q <= T_IDLE;
`ifdef PREFETCH_ABORT_EN
            if (state_q == S_HALT || abort_enq) state_q <= S_HALT;
            else
`endif
            if (slot_ok) begin
                state_q <= S_FETCH;
                trans_q <= seq_ok ? T_SEQ : T_NONSEQ;
            end else begin
                state_q <= S_STALL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_vld_q  <= 1'b0;
            resp_addr_q <= RESET_VECTOR;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
        end else begin
            resp_vld_q  <= resp_vld_d;
            resp_addr_q <= addr_q;
            if (bus.flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
            end else begin
                if (enq) wptr_q <= wptr_q + PW'(1);
                if (deq) rptr_q <= rptr_q + PW'(1);
                count_q <= count_q + (PW+1)'(enq) - (PW+1)'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !reset) begin
            data_mem[wptr_q] <= bus.rdata;
            addr_mem[wptr_q] <= resp_addr_q;
        end
    end

    assign bus.addr        = addr_q;
    assign bus.trans       = trans_q;
    assign bus.size        = 2'b10;
    assign bus.prot        = 2'b00;
    assign bus.write       = 1'b0;
    assign bus.instr_valid = instr_valid;
    assign bus.instr       = data_mem[rptr_q];
    assign bus.instr_addr  = addr_mem[rptr_q];
endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: per-cycle vector table for the bus/handshake timing,
// a queue scoreboard for delivered instructions, and hand sequences for reset and abort.
module tb_instruction_prefetch_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instruction_prefetch_unit_if #(.ADDR_WIDTH(32)) bus ();

    instruction_prefetch_unit #(.DEPTH(4), .ADDR_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

`ifdef PREFETCH_ABORT_EN
    localparam bit AEN = 1'b1;
`else
    localparam bit AEN = 1'b0;
`endif

    typedef struct { logic [31:0] addr; logic [31:0] data; logic abt; } exp_t;
    typedef struct {
        logic rb, rdy, fl; logic [31:0] fa;
        logic ca; logic [1:0] et; logic [31:0] ea; logic ev; logic [31:0] eia;
    } vec_t;

    exp_t        sbq[$];
    vec_t        vt[32];
    int          nv = 0, nvec = 0, nerr = 0;
    logic        fetch_act = 1'b0, resp_act = 1'b0, halted = 1'b0, abort_on = 1'b0;
    logic [31:0] fetch_addr = '0, resp_addr = '0, abort_addr = '0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic add(input logic rb, input logic rdy, input logic fl, input logic [31:0] fa,
                       input logic ca, input logic [1:0] et, input logic [31:0] ea,
                       input logic ev, input logic [31:0] eia);
        vt[nv] = '{rb, rdy, fl, fa, ca, et, ea, ev, eia};
        nv++;
    endtask

    // One clock cycle: drive inputs just after the edge, check the scoreboard at negedge.
    task automatic cyc(input logic rst, input logic rdy, input logic fl, input logic [31:0] fa);
        @(posedge clk); #1;
        reset = rst; bus.instr_ready = rdy; bus.flush = fl; bus.flush_addr = fa;
        resp_act  = fetch_act;
        resp_addr = fetch_addr;
        bus.rdata = resp_act ? word(resp_addr) : 32'h0;
        bus.abort = resp_act && abort_on && (resp_addr == abort_addr);
        @(negedge clk);
        chk("sb valid", 32'(bus.instr_valid), 32'(sbq.size() != 0));
        if (sbq.size() != 0 && bus.instr_valid) begin
            chk("sb instr", bus.instr, sbq[0].data);
            chk("sb instr_addr", bus.instr_addr, sbq[0].addr);
            chk("sb instr_abort", 32'(bus.instr_abort), 32'(sbq[0].abt));
            if (rdy && !fl && !rst) void'(sbq.pop_front());
        end
        if (rst || fl) begin
            sbq.delete();
            halted = 1'b0;
        end else if (resp_act && !halted) begin
            sbq.push_back('{resp_addr, word(resp_addr), AEN && bus.abort});
            if (AEN && bus.abort) halted = 1'b1;
        end
        fetch_act  = (bus.trans != 2'b00) && !rst && !fl;
        fetch_addr = bus.addr;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        bus.instr_ready = 1'b0; bus.flush = 1'b0; bus.flush_addr = '0;
        bus.rdata = '0; bus.abort = 1'b0;

        // Streaming with ready=1, flush to 0x103, flush to the top of the address space.
        add(1, 1, 0, 32'h0,        1, 2'b00, 32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b10, 32'h0,        0, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h4,        0, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h8,        1, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'hC,        1, 32'h4);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h10,       1, 32'h8);
        add(0, 1, 1, 32'h103,      0, 2'b11, 32'h14,       1, 32'hC);
        add(0, 1, 0, 32'h0,        0, 2'b10, 32'h100,      0, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h104,      0, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h108,      1, 32'h100);
        add(0, 1, 1, 32'hFFFFFFF8, 0, 2'b11, 32'h10C,      1, 32'h104);
        add(0, 1, 0, 32'h0,        0, 2'b10, 32'hFFFFFFF8, 0, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'hFFFFFFFC, 0, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b10, 32'h0,        1, 32'hFFFFFFF8);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h4,        1, 32'hFFFFFFFC);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h8,        1, 32'h0);
        // Decode stalled from reset: four fetches fill the FIFO, then release.
        add(1, 0, 0, 32'h0,        1, 2'b00, 32'h0,        0, 32'h0);
        add(0, 0, 0, 32'h0,        0, 2'b10, 32'h0,        0, 32'h0);
        add(0, 0, 0, 32'h0,        0, 2'b11, 32'h4,        0, 32'h0);
        add(0, 0, 0, 32'h0,        0, 2'b11, 32'h8,        1, 32'h0);
        add(0, 0, 0, 32'h0,        0, 2'b11, 32'hC,        1, 32'h0);
        add(0, 0, 0, 32'h0,        0, 2'b00, 32'h0,        1, 32'h0);
        add(0, 0, 0, 32'h0,        0, 2'b00, 32'h0,        1, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b00, 32'h0,        1, 32'h0);
        add(0, 1, 0, 32'h0,        0, 2'b10, 32'h10,       1, 32'h4);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h14,       1, 32'h8);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h18,       1, 32'hC);
        add(0, 1, 0, 32'h0,        0, 2'b11, 32'h1C,       1, 32'h10);

        for (int i = 0; i < nv; i++) begin
            if (vt[i].rb) do_reset();
            cyc(1'b0, vt[i].rdy, vt[i].fl, vt[i].fa);
            chk($sformatf("v%0d trans", i), 32'(bus.trans), 32'(vt[i].et));
            if (vt[i].ca || vt[i].et != 2'b00) chk($sformatf("v%0d addr", i), bus.addr, vt[i].ea);
            chk($sformatf("v%0d instr_valid", i), 32'(bus.instr_valid), 32'(vt[i].ev));
            if (vt[i].ev) chk($sformatf("v%0d instr_addr", i), bus.instr_addr, vt[i].eia);
            else          chk($sformatf("v%0d instr_abort", i), 32'(bus.instr_abort), 32'h0);
            if (vt[i].rb) chk($sformatf("v%0d size/prot/write", i),
                              32'({bus.size, bus.prot, bus.write}), 32'b10000);
        end

        // Reset while three entries are queued.
        do_reset();
        repeat (5) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        chk("rst3 valid before", 32'(bus.instr_valid), 32'h1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        chk("rst3 valid after", 32'(bus.instr_valid), 32'h0);
        chk("rst3 trans after", 32'(bus.trans), 32'h0);
        chk("rst3 addr after", bus.addr, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("rst3 restart trans", 32'(bus.trans), 32'h2);
        chk("rst3 restart addr", bus.addr, 32'h0);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);

        // Abort returned for the fetch of 0x8.
        do_reset();
        abort_on = 1'b1; abort_addr = 32'h8;
        repeat (5) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("abt instr_addr", bus.instr_addr, 32'h8);
`ifdef PREFETCH_ABORT_EN
        chk("abt flag", 32'(bus.instr_abort), 32'h1);
        chk("abt halt trans0", 32'(bus.trans), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("abt halt trans1", 32'(bus.trans), 32'h0);
        chk("abt halt valid", 32'(bus.instr_valid), 32'h0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("abt halt trans2", 32'(bus.trans), 32'h0);
`else
        chk("abt flag", 32'(bus.instr_abort), 32'h0);
        chk("abt run trans0", 32'(bus.trans), 32'h3);
        chk("abt run addr0", bus.addr, 32'h10);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("abt run addr1", bus.addr, 32'h14);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("abt run addr2", bus.addr, 32'h18);
`endif
        cyc(1'b0, 1'b1, 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        chk("abt flush trans", 32'(bus.trans), 32'h2);
        chk("abt flush addr", bus.addr, 32'h40);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        abort_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
